// File: rtl/inst_sram_resp.sv
// Instruction-SRAM responder: answers pc/inst_sram_en fetch requests with a
// tagged 32-bit word after LATENCY cycles. Stage 1 captures the array read,
// the pc and the decode error; stages 2..LATENCY are plain delay registers.
// Data/pc/err registers only load on a valid beat, so the outputs hold their
// last response through bubbles.

// One pipeline stage: valid always advances, payload loads only when valid.
module inst_sram_resp_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  input  logic [31:0] in_dat,
  input  logic [31:0] in_pc,
  input  logic        in_err,
  output logic        out_vld,
  output logic [31:0] out_dat,
  output logic [31:0] out_pc,
  output logic        out_err
);

  // Sync reset flushes the beat; payload is held across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      out_pc  <= '0;
      out_err <= 1'b0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_dat <= in_dat;
        out_pc  <= in_pc;
        out_err <= in_err;
      end
    end
  end

endmodule

module inst_sram_resp #(
  parameter int          AW        = 10,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   pc,
  input  logic          inst_sram_en,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   inst,
  output logic [31:0]   inst_pc,
  output logic          inst_valid,
  output logic          inst_err,
  output logic [31:0]   resp_count
);

  localparam int DEPTH = 1 << AW;

  logic [31:0]   mem [DEPTH];

  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic          misalign;
  logic          out_of_range;
  logic          req_err;

  // Index 0 is the combinational request beat; index s is the output of stage s.
  logic [LATENCY:0]       vld_pipe;
  logic [LATENCY:0]       err_pipe;
  logic [LATENCY:0][31:0] dat_pipe;
  logic [LATENCY:0][31:0] pc_pipe;

  // Decode relative to BASE_ADDR; modular subtract so pc wrap decodes normally.
  assign offset       = pc - BASE_ADDR;
  assign word_idx     = offset[AW+1:2];
  assign misalign     = |offset[1:0];
  assign out_of_range = |offset[31:AW+2];
  assign req_err      = misalign | out_of_range;

  // Preload port; independent of rst so programs can be loaded under reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The read happens before the write lands on the same edge, so a
  // same-word read/write returns the old contents. Errored requests see NOP.
  assign vld_pipe[0] = inst_sram_en;
  assign err_pipe[0] = req_err;
  assign pc_pipe[0]  = pc;
  assign dat_pipe[0] = req_err ? 32'h0000_0000 : mem[word_idx];

  genvar s;
  generate
    for (s = 1; s <= LATENCY; s++) begin : g_stage
      inst_sram_resp_stage u_stage (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (vld_pipe[s-1]),
        .in_dat  (dat_pipe[s-1]),
        .in_pc   (pc_pipe[s-1]),
        .in_err  (err_pipe[s-1]),
        .out_vld (vld_pipe[s]),
        .out_dat (dat_pipe[s]),
        .out_pc  (pc_pipe[s]),
        .out_err (err_pipe[s])
      );
    end
  endgenerate

  assign inst_valid = vld_pipe[LATENCY];
  assign inst       = dat_pipe[LATENCY];
  assign inst_pc    = pc_pipe[LATENCY];
  assign inst_err   = err_pipe[LATENCY];

  // Count on the edge a response appears, so the count includes the beat on the outputs.
  always_ff @(posedge clk) begin
    if (rst) resp_count <= '0;
    else     resp_count <= resp_count + {31'd0, vld_pipe[LATENCY-1]};
  end

endmodule
